next_pc_ctrl: RTL



---
 rtl/next_pc_ctrl_pkg.sv | 37 +++
 rtl/next_pc_ctrl_branch_cmp.sv | 42 ++++
 rtl/next_pc_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/next_pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// next_pc_ctrl_pkg
//   Shared definitions for the next-PC control slice:
//     - control-transfer kind codes (same encoding as the 4-way PC mux select)
//     - branch funct3 condition codes
//     - fetch-control state encoding
//     - small helper for word-alignment tests
// -----------------------------------------------------------------------------
package next_pc_ctrl_pkg;

  // Control-transfer kind, doubles as the PC mux select code
  localparam logic [1:0] KIND_SEQ  = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  // Branch conditions (funct3); 010 and 011 are reserved and never taken
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Fetch-control states; explicit values keep the legacy encoding
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } state_t;

  // True when the two address LSBs describe a word-aligned target
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_ctrl_branch_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
//   Purely combinational branch-condition evaluator.
//   Ports:
//     funct3 [2:0]     branch condition code
//     rs1    [XLEN-1:0] first operand
//     rs2    [XLEN-1:0] second operand
//     cond             1 when the condition holds (reserved codes give 0)
// -----------------------------------------------------------------------------
module branch_cmp
  import next_pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = ~lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/next_pc_ctrl.sv
// -----------------------------------------------------------------------------
// next_pc_ctrl
//   Control end of the next-PC select path. Resolves branches/jumps coming out
//   of EX, owns the architectural fetch PC, drives the instruction-fetch
//   request handshake and the IF/ID flush.
//
//   Ports:
//     clk, rst_n          core clock (rising edge), async active-low reset
//     ex_valid            EX holds a valid control-transfer candidate
//     ex_kind [1:0]       00 seq, 01 branch, 10 jal, 11 jalr
//     ex_funct3 [2:0]     branch condition
//     ex_pc/ex_imm        PC and sign-extended immediate of the EX instruction
//     ex_rs1_val/rs2_val  register operands
//     stall_in            hazard stall, suppresses a new fetch request
//     if_ready            imem accepts the current request
//     if_req              fetch request valid
//     pc_out              registered fetch address
//     pc_sel              registered select of the last EX transfer
//     branch_check        registered taken flag of the last EX transfer
//     flush               one-cycle IF/ID kill after a redirect lands
//     misalign            one-cycle pulse for a suppressed misaligned target
// -----------------------------------------------------------------------------
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1_val,
  input  logic [XLEN-1:0] ex_rs2_val,
  input  logic            stall_in,
  input  logic            if_ready,
  output logic            if_req,
  output logic [XLEN-1:0] pc_out,
  output logic [1:0]      pc_sel,
  output logic            branch_check,
  output logic            flush,
  output logic            misalign
);

  state_t          state;
  logic            hold;
  logic [XLEN-1:0] pend;

  logic            cond;
  logic            is_jump;
  logic            redirect;
  logic            aligned;
  logic            accept;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_seq;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_branch_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1_val),
    .rs2    (ex_rs2_val),
    .cond   (cond)
  );

  // Target generation; jalr clears bit 0 of rs1+imm
  always_comb begin
    br_tgt   = ex_pc + ex_imm;
    jalr_tgt = (ex_rs1_val + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
    target   = (ex_kind == KIND_JALR) ? jalr_tgt : br_tgt;
    aligned  = is_word_aligned(target[1:0]);
  end

  always_comb begin
    is_jump  = (ex_kind == KIND_JAL) || (ex_kind == KIND_JALR);
    redirect = ex_valid && (is_jump || ((ex_kind == KIND_BR) && cond));
  end

  // Request is combinational so hold keeps it asserted across stalls
  always_comb begin
    if_req = (state != BOOT) && (!stall_in || hold);
    accept = if_req && if_ready;
    pc_seq = pc_out + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      hold         <= 1'b0;
      pend         <= '0;
      pc_out       <= RESET_PC;
      pc_sel       <= KIND_SEQ;
      branch_check <= 1'b0;
      flush        <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      flush    <= 1'b0;
      misalign <= 1'b0;

      // Once set, hold only clears on acceptance of the stalled request
      if (hold) begin
        hold <= ~accept;
      end else begin
        hold <= if_req & ~if_ready;
      end

      case (state)
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          if (ex_valid) begin
            pc_sel       <= ex_kind;
            branch_check <= cond & (ex_kind == KIND_BR);
          end

          if (redirect && !aligned) begin
            // Misaligned targets are dropped; fetch carries on sequentially
            misalign <= 1'b1;
            if (accept) begin
              pc_out <= pc_seq;
            end
          end else if (redirect && hold && !accept) begin
            // Outstanding request must keep its address; park the target
            pend  <= target;
            state <= PEND;
          end else if (redirect) begin
            pc_out <= target;
            flush  <= 1'b1;
          end else if (accept) begin
            pc_out <= pc_seq;
          end
        end

        PEND: begin
          if (accept) begin
            pc_out <= pend;
            flush  <= 1'b1;
            state  <= RUN;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
